// File: rtl/axis_downsize_adapter_if.sv
// axis_downsize_adapter_if: AXI-Stream bus bundle with master/slave views.
interface axis_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;
  modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_downsize_adapter.sv
// axis_downsize_adapter: splits one wide AXI-Stream beat into narrow beats, LS segment first.
module axis_downsize_adapter #(
  parameter int S_DATA_WIDTH  = 64,
  parameter int S_KEEP_ENABLE = (S_DATA_WIDTH > 8),
  parameter int S_KEEP_WIDTH  = (S_DATA_WIDTH / 8),
  parameter int M_DATA_WIDTH  = 8,
  parameter int M_KEEP_ENABLE = (M_DATA_WIDTH > 8),
  parameter int M_KEEP_WIDTH  = (M_DATA_WIDTH / 8),
  parameter int ID_ENABLE     = 0,
  parameter int ID_WIDTH      = 8,
  parameter int DEST_ENABLE   = 0,
  parameter int DEST_WIDTH    = 8,
  parameter int USER_ENABLE   = 1,
  parameter int USER_WIDTH    = 1
) (
  input logic    clk,
  input logic    rst,
  axis_if.slave  s_axis,
  axis_if.master m_axis
);
  localparam int SEG_COUNT = S_KEEP_WIDTH / M_KEEP_WIDTH;
  localparam int SEG_W     = SEG_COUNT > 1 ? $clog2(SEG_COUNT) : 1;
  if (S_KEEP_WIDTH % M_KEEP_WIDTH != 0 || SEG_COUNT < 1 || S_DATA_WIDTH % M_DATA_WIDTH != 0) begin : g_bad_ratio
    $error("axis_downsize_adapter: input width must be an integer multiple of output width");
  end
  logic [S_DATA_WIDTH-1:0] r_data;
  logic [S_KEEP_WIDTH-1:0] r_keep;
  logic                    r_last;
  logic                    r_valid;
  logic [ID_WIDTH-1:0]     r_id;
  logic [DEST_WIDTH-1:0]   r_dest;
  logic [USER_WIDTH-1:0]   r_user;
  logic [SEG_W-1:0]        r_seg;
  logic [SEG_W-1:0]        r_last_seg;
  logic [SEG_W-1:0]        w_last_seg;
  logic [S_KEEP_WIDTH-1:0] w_keep;
  logic                    w_final;
  logic                    w_s_ready;
  logic                    w_load;
  // Mid-frame words emit every segment; the frame's final word stops at its highest kept segment.
  always_comb begin
    w_keep = S_KEEP_ENABLE != 0 ? s_axis.tkeep : '1;
    w_last_seg = '0;
    for (int i = 0; i < SEG_COUNT; i++)
      if (|w_keep[i*M_KEEP_WIDTH +: M_KEEP_WIDTH]) w_last_seg = SEG_W'(i);
    if (!s_axis.tlast) w_last_seg = SEG_W'(SEG_COUNT - 1);
  end
  assign w_final   = r_seg == r_last_seg;
  assign w_s_ready = !rst && (!r_valid || (m_axis.tready && w_final));
  assign w_load    = s_axis.tvalid && w_s_ready;
  assign s_axis.tready = w_s_ready;
  assign m_axis.tvalid = r_valid;
  assign m_axis.tdata  = r_data[M_DATA_WIDTH-1:0];
  assign m_axis.tkeep  = M_KEEP_ENABLE != 0 ? r_keep[M_KEEP_WIDTH-1:0] : '1;
  assign m_axis.tlast  = r_valid && r_last && w_final;
  assign m_axis.tid    = r_id;
  assign m_axis.tdest  = r_dest;
  assign m_axis.tuser  = r_user;
  // The held word shifts down so the current segment always sits in the low bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data     <= '0;
      r_keep     <= '0;
      r_last     <= 1'b0;
      r_valid    <= 1'b0;
      r_id       <= '0;
      r_dest     <= '0;
      r_user     <= '0;
      r_seg      <= '0;
      r_last_seg <= '0;
    end else if (w_load) begin
      r_data     <= s_axis.tdata;
      r_keep     <= w_keep;
      r_last     <= s_axis.tlast;
      r_valid    <= 1'b1;
      r_id       <= ID_ENABLE != 0 ? s_axis.tid : '0;
      r_dest     <= DEST_ENABLE != 0 ? s_axis.tdest : '0;
      r_user     <= USER_ENABLE != 0 ? s_axis.tuser : '0;
      r_seg      <= '0;
      r_last_seg <= w_last_seg;
    end else if (r_valid && m_axis.tready) begin
      if (!w_final) begin
        r_data <= r_data >> M_DATA_WIDTH;
        r_keep <= r_keep >> M_KEEP_WIDTH;
        r_seg  <= r_seg + 1'b1;
      end else begin
        r_valid <= 1'b0;
        r_seg   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_axis_downsize_adapter.sv
// tb_axis_downsize_adapter: directed checks of the 64->8 bit downsizer.
module tb_axis_downsize_adapter;
  typedef struct {logic [63:0] d; logic [7:0] k; logic l; logic u;} word_t;
  typedef struct {logic [7:0] d; logic k; logic l; logic u;} beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  word_t wq[$];
  beat_t bq[$];
  int acc_cyc[$];
  int beat_cyc[$];
  int rdy_cnt;
  int last_cnt;
  logic last_rdy;
  axis_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) s_if ();
  axis_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1)) m_if ();
  axis_downsize_adapter #(.M_KEEP_ENABLE(1)) dut (.clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic add_word(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    word_t w;
    w.d = d; w.k = k; w.l = l; w.u = u;
    wq.push_back(w);
  endtask
  task automatic add_beat(input logic [7:0] d, input logic k, input logic l, input logic u);
    beat_t b;
    b.d = d; b.k = k; b.l = l; b.u = u;
    bq.push_back(b);
  endtask
  task automatic run(input int rdy_pct, input int budget);
    int cyc = 0;
    logic stall = 1'b0;
    logic [10:0] prev = '0;
    logic [10:0] cur;
    acc_cyc.delete();
    beat_cyc.delete();
    rdy_cnt = 0;
    last_cnt = 0;
    last_rdy = 1'b0;
    while ((wq.size() != 0 || bq.size() != 0) && cyc < budget) begin
      @(negedge clk);
      m_if.tready = $urandom_range(99) < rdy_pct;
      if (wq.size() != 0) begin
        s_if.tvalid = 1'b1;
        s_if.tdata = wq[0].d;
        s_if.tkeep = wq[0].k;
        s_if.tlast = wq[0].l;
        s_if.tuser = wq[0].u;
      end else s_if.tvalid = 1'b0;
      #1;
      cur = {m_if.tkeep, m_if.tlast, m_if.tuser, m_if.tdata};
      if (stall) chk("hold", cur, prev);
      if (acc_cyc.size() == 1 && s_if.tready) rdy_cnt++;
      if (m_if.tvalid && m_if.tready) begin
        if (bq.size() == 0) chk("extra_beat", 1, 0);
        else begin
          chk($sformatf("beat%0d", beat_cyc.size()), cur, {bq[0].k, bq[0].l, bq[0].u, bq[0].d});
          void'(bq.pop_front());
        end
        if (m_if.tlast) begin
          last_cnt++;
          last_rdy = s_if.tready;
        end
        beat_cyc.push_back(cyc);
      end
      if (s_if.tvalid && s_if.tready) begin
        void'(wq.pop_front());
        acc_cyc.push_back(cyc);
      end
      stall = m_if.tvalid && !m_if.tready;
      prev = cur;
      cyc++;
    end
    chk("timeout", {wq.size() != 0, bq.size() != 0}, 0);
    wq.delete();
    bq.delete();
    @(negedge clk);
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    #1;
    chk("drained", m_if.tvalid, 0);
  endtask
  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tkeep = '0;
    s_if.tlast = 1'b0;
    s_if.tid = '0;
    s_if.tdest = '0;
    s_if.tuser = '0;
    m_if.tready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mvalid", m_if.tvalid, 0);
    chk("rst_out", {m_if.tlast, m_if.tdata, m_if.tuser, m_if.tid, m_if.tdest}, 0);
    chk("rst_sready", s_if.tready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_sready", s_if.tready, 1);
    // full word, tlast only on final byte, first beat one cycle after accept
    add_word(64'h8877665544332211, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) add_beat(8'(8'h11 * (i + 1)), 1'b1, i == 7, 1'b0);
    run(100, 50);
    chk("t1_latency", beat_cyc[0] - acc_cyc[0], 1);
    chk("t1_contig", beat_cyc[7] - beat_cyc[0], 7);
    // partial final word with tuser
    add_word(64'h0000000000CCBBAA, 8'h07, 1'b1, 1'b1);
    add_beat(8'hAA, 1'b1, 1'b0, 1'b1);
    add_beat(8'hBB, 1'b1, 1'b0, 1'b1);
    add_beat(8'hCC, 1'b1, 1'b1, 1'b1);
    run(100, 50);
    chk("t2_rdy_at_last", last_rdy, 1);
    // back-to-back words, no bubbles
    add_word(64'h0807060504030201, 8'hFF, 1'b0, 1'b0);
    add_word(64'h100F0E0D0C0B0A09, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) add_beat(8'(i + 1), 1'b1, i == 15, 1'b0);
    run(100, 60);
    chk("t3_contig", beat_cyc[15] - beat_cyc[0], 15);
    chk("t3_accept_gap", acc_cyc[1] - acc_cyc[0], 8);
    chk("t3_rdy_once", rdy_cnt, 1);
    // 20-byte frame under random backpressure
    add_word(64'h0807060504030201, 8'hFF, 1'b0, 1'b0);
    add_word(64'h100F0E0D0C0B0A09, 8'hFF, 1'b0, 1'b0);
    add_word(64'hDEADBEEF14131211, 8'h0F, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) add_beat(8'(i + 1), 1'b1, i == 19, 1'b0);
    run(50, 400);
    chk("t4_one_last", last_cnt, 1);
    // empty keep on final word
    add_word(64'h7766554433221155, 8'h00, 1'b1, 1'b0);
    add_beat(8'h55, 1'b0, 1'b1, 1'b0);
    run(100, 20);
    chk("t5_nbeats", beat_cyc.size(), 1);
    // reset mid-frame
    @(negedge clk);
    s_if.tvalid = 1'b1;
    s_if.tdata = 64'h8877665544332211;
    s_if.tkeep = 8'hFF;
    s_if.tlast = 1'b1;
    m_if.tready = 1'b1;
    #1;
    chk("t6_accept", s_if.tready, 1);
    @(negedge clk);
    s_if.tvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_beat4", {m_if.tvalid, m_if.tdata}, 9'h144);
    rst = 1'b1;
    #1;
    chk("t6_rst_mvalid", m_if.tvalid, 0);
    chk("t6_rst_out", {m_if.tlast, m_if.tdata}, 0);
    chk("t6_rst_sready", s_if.tready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_rel_sready", s_if.tready, 1);
    chk("t6_rel_mvalid", m_if.tvalid, 0);
    add_word(64'h0807060504030201, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) add_beat(8'(i + 1), 1'b1, i == 7, 1'b0);
    run(100, 50);
    chk("t6_nbeats", beat_cyc.size(), 8);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axis_downsize_adapter.md
Name: axis_downsize_adapter

Overview:
- Registered AXI-Stream width downsizer: accepts one wide beat (default 64 bit) and emits it as consecutive narrow beats (default 8 bit), least-significant segment first.
- Complement of the upsizing FIFO adapter path. Used on the read side of wide buffers to feed byte-wide consumers such as MAC TX interfaces.
- Holds one wide word plus a segment counter, and sustains one narrow beat per cycle across word boundaries.

Parameters:
- S_DATA_WIDTH, 64, input tdata width; must be an integer multiple of M_DATA_WIDTH.
- S_KEEP_ENABLE, (S_DATA_WIDTH>8), use s_axis_tkeep; when 0, tkeep is treated as all ones.
- S_KEEP_WIDTH, (S_DATA_WIDTH/8), input tkeep width.
- M_DATA_WIDTH, 8, output tdata width.
- M_KEEP_ENABLE, (M_DATA_WIDTH>8), drive m_axis_tkeep; when 0, m_axis_tkeep is tied to all ones.
- M_KEEP_WIDTH, (M_DATA_WIDTH/8), output tkeep width.
- ID_ENABLE, 0, pass tid; when 0, m_axis_tid is 0.
- ID_WIDTH, 8, tid width.
- DEST_ENABLE, 0, pass tdest; when 0, m_axis_tdest is 0.
- DEST_WIDTH, 8, tdest width.
- USER_ENABLE, 1, pass tuser; when 0, m_axis_tuser is 0.
- USER_WIDTH, 1, tuser width.
- Derived: SEG_COUNT = S_KEEP_WIDTH/M_KEEP_WIDTH. Elaboration error if the ratio is not an integer or SEG_COUNT < 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_axis_tdata  in  S_DATA_WIDTH  wide data
- s_axis_tkeep  in  S_KEEP_WIDTH  byte enables
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  end of frame
- s_axis_tid  in  ID_WIDTH  stream id
- s_axis_tdest  in  DEST_WIDTH  destination
- s_axis_tuser  in  USER_WIDTH  sideband (bad-frame flag)
- m_axis_tdata  out  M_DATA_WIDTH  narrow data
- m_axis_tkeep  out  M_KEEP_WIDTH  byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  end of frame
- m_axis_tid  out  ID_WIDTH  stream id
- m_axis_tdest  out  DEST_WIDTH  destination
- m_axis_tuser  out  USER_WIDTH  sideband

Behaviour:
- Reset (async assert, sync release): m_axis_tvalid=0, m_axis_tlast=0, all m_axis data/sideband=0, segment counter=0, held word cleared.
  - s_axis_tready=0 while rst is high; s_axis_tready=1 on the first cycle after release.
  - Reset mid-frame discards the held word and remaining segments; no partial tlast is emitted.
- Storage: one wide register (data, keep, last, id, dest, user), valid flag, segment index seg (0..SEG_COUNT-1), and last_seg = index of the final segment to emit for the held word.
- last_seg: if the word has tlast=0, last_seg = SEG_COUNT-1 and all segments are emitted regardless of keep. If tlast=1, last_seg = highest segment with any keep bit set; if keep is all zero, last_seg = 0.
- Outputs are registered. m_axis_tdata/tkeep = held word segment seg. tid/tdest/tuser are replicated on every segment. m_axis_tlast = held tlast AND (seg == last_seg).
- Latency: a word accepted on cycle N presents segment 0 on cycle N+1.
- s_axis_tready = !valid OR (m_axis_tready AND seg == last_seg). Loading a new word on the same cycle the final segment is consumed gives zero bubbles.
- Per output handshake (m_axis_tvalid && m_axis_tready):
  - If seg < last_seg: seg increments by 1.
  - Otherwise: seg resets to 0, and valid = s_axis_tvalid && s_axis_tready (new word loaded) or 0 (buffer drained).
- Holding: m_axis_tvalid and all m_axis fields stay stable while m_axis_tready=0.
- Pass-through: SEG_COUNT==1 degenerates to a one-register pipeline stage.
- Input tkeep is not validated; keep holes inside a segment pass through unchanged on m_axis_tkeep.

Test Plan:
- Word 0x8877665544332211, keep 0xFF, tlast=1, m_axis_tready=1 -> 8 beats 0x11,0x22,…,0x88 on 8 consecutive cycles, first beat one cycle after accept; tlast only on 0x88.
- Word 0x0000000000CCBBAA, keep 0x07, tlast=1, tuser=1 -> 3 beats 0xAA,0xBB,0xCC; tlast on 0xCC; tuser=1 on all 3; s_axis_tready=1 in the same cycle 0xCC is accepted.
- Two back-to-back full words (tlast=0 then tlast=1), s_axis_tvalid held high, m_axis_tready=1 -> 16 beats in 16 consecutive cycles with no bubble; s_axis_tready high for exactly one cycle between the words.
- Random m_axis_tready (50%) over a 20-byte frame (3 words; last word keep 0x0F) -> 20 bytes in order, output held stable during stalls, exactly one tlast.
- Keep 0x00 with tlast=1 -> single beat, tkeep 0, tlast=1.
- Assert rst after beat 3 of 8 -> m_axis_tvalid drops immediately; s_axis_tready=0 during reset; after release a new word 0x0807060504030201 emits 0x01..0x08 cleanly with no stale data.
